lr_column_buffer: RTL and testbench
===================================

# lr_column_buffer

Row-window store for right-view disparities (disp_R) feeding the LR check stage. The block accepts the disp_R raster stream one pixel per cycle and keeps the five most recently completed rows. It answers each read address from the LR check engine with the vertical 1x5 column at that x coordinate, with a fixed 1-cycle latency. It is the responder side of the check engine's rd_addr / column-data interface.

## Interface
- WIDTH, 16, bits per disparity (8 integer + 8 fraction)
- CWIDTH, 80, column output width; must equal 5*WIDTH
- AWIDTH, 9, address width
- DEPTH, 512, entries per row bank; must equal 2^AWIDTH
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clken  in  1  global clock enable; when low, every register holds and memories are neither read nor written
- img_width  in  11  pixels per row, legal range 1..DEPTH
- sof  in  1  start-of-frame, single-cycle, synchronous
- wr_en  in  1  wr_data valid this cycle
- wr_data  in  WIDTH  disp_R pixel in raster order
- rd_addr  in  AWIDTH  column x coordinate requested by the check engine
- data_out_col  out  CWIDTH  lane i = bits [WIDTH*(i+1)-1 : WIDTH*i]; lane 0 = oldest row, lane 2 = centre row, lane 4 = newest completed row
- col_ready  out  1  high once five complete rows are stored in the current frame
- row_done  out  1  one-cycle pulse after the last pixel of a row is written
- wr_x  out  AWIDTH  x coordinate of the next pixel to be written

## Operation
- Storage is six banks of DEPTH x WIDTH, each with one write port and one read port. Bank wr_row (0..5) receives the row currently being written. The other five banks hold completed rows, so reads and writes never touch the same bank.
- Write path, active when clken=1 and wr_en=1:
  - bank[wr_row][wr_x] <= wr_data.
  - If wr_x == img_width-1: wr_x <= 0, wr_row <= (wr_row+1) mod 6, rows_done <= min(rows_done+1, 5), row_done <= 1.
  - Otherwise wr_x <= wr_x+1.
- row_done is 0 on every other clken cycle.
- col_ready = (rows_done == 5), registered.
- Read path, active every cycle with clken=1: lane i <= bank[(wr_row+1+i) mod 6][rd_addr] for i = 0..4. The read uses the wr_row value held before the edge.
- sof has priority over other events. On sof (with clken=1):
  - wr_x, wr_row, rows_done, col_ready and row_done are cleared.
  - If wr_en is also high, wr_data is written to bank 0 at x=0 and wr_x becomes 1.
  - The read path still executes on that cycle using the old wr_row.
- If rd_addr ≥ img_width, or col_ready is 0, the returned data is stale memory content. The block does not flag these cases. The check engine is responsible for boundary handling, including out-of-range addresses formed as DEPTH+x-d.
- A change to img_width takes effect at the next end-of-row compare. A change mid-row is not supported.

## Timing
- Reset values: data_out_col=0, col_ready=0, row_done=0, wr_x=0. Internal wr_row=0 and rows_done=0. Memory contents are not reset.
- Read latency: rd_addr sampled at edge N (clken=1) gives data_out_col valid after edge N. The value holds until the next clken=1 edge.
- Write-to-read visibility: a row becomes readable on the first read edge after the edge where its last pixel is written.
- col_ready and row_done update on that same edge.
- clken=0 in the middle of a stream: wr_en is ignored and all outputs hold. Throughput is 1 write + 1 read per enabled cycle with no stalls.
- Reset asserted mid-row: outputs clear asynchronously. The following frame must begin with sof or directly with x=0 data.

## Test plan
- Reset: assert rst with random inputs -> data_out_col=0, col_ready=0, row_done=0, wr_x=0. All four hold while clken=0.
- Fill, img_width=8, pixel = row*16+x for rows 0..4:
  - row_done pulses 5 times.
  - col_ready rises with the 5th pulse.
  - rd_addr=3 on the next cycle -> data_out_col = {0x0043,0x0033,0x0023,0x0013,0x0003} (lane 4..0), one cycle later.
- Concurrent write, continuing the fill stream: while row 5 streams, rd_addr=3 each cycle -> still rows 0..4.
  - After row 5 completes, rd_addr=3 -> {0x0053,0x0043,0x0033,0x0023,0x0013}.
- Bank wrap: 12 rows at img_width=8, then rd_addr=7 -> lanes 0..4 = 0x0077, 0x0087, 0x0097, 0x00A7, 0x00B7. col_ready stays 1.
- clken gating: drop clken for 3 cycles mid-row with wr_en=1 and changing rd_addr -> data_out_col, wr_x and col_ready frozen, no pixels written.
  - After re-enable, the next pixel lands at the held wr_x.
- sof mid-frame: after 2 rows + 3 pixels, pulse sof with wr_en=1 -> col_ready=0, wr_x=1, pixel stored at bank 0 x 0.
  - Five further rows are needed before col_ready is set again.

Source files
------------

// File: rtl/lr_column_buffer.sv
// lr_column_buffer
// Row-window store for right-view disparities. Accepts the disp_R raster
// stream one pixel per cycle into a ring of six row banks and answers each
// rd_addr from the LR check engine with the 1x5 vertical column formed by
// the five most recently completed rows, one cycle later.
//
// Bank ring: bank wr_row is always the row being written; the five banks
// that follow it (mod 6) hold completed rows, oldest first. This keeps the
// read and write ports on disjoint banks, so no read-during-write hazards.
module lr_column_buffer #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 80,
    parameter int AWIDTH = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [10:0]       img_width,
    input  logic              sof,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [CWIDTH-1:0] data_out_col,
    output logic              col_ready,
    output logic              row_done,
    output logic [AWIDTH-1:0] wr_x
);

    localparam int NBANK = 6;
    localparam int NLANE = 5;
    localparam int IW    = 11;

    localparam logic [2:0] LAST_BANK = 3'd5;
    localparam logic [2:0] FULL_ROWS = 3'd5;

    // ------------------------------------------------------------------
    // Write-side control state
    // ------------------------------------------------------------------
    logic [AWIDTH-1:0] wr_x_reg, wr_x_next;
    logic [2:0]        wr_row_reg, wr_row_next;
    logic [2:0]        rows_done_reg, rows_done_next;
    logic              col_ready_reg, col_ready_next;
    logic              row_done_reg, row_done_next;

    // Read-side pipeline state: which bank ring position the registered
    // bank reads correspond to, and whether any read has happened yet.
    logic [2:0]        rd_sel_reg;
    logic              rd_valid_reg;

    // Memory write port signals shared by all banks
    logic              wr_fire;
    logic [2:0]        wr_bank;
    logic [AWIDTH-1:0] wr_addr;
    logic              row_end;
    logic              sof_row_end;

    // Registered read data from every bank, one lane-width slice per bank
    logic [NBANK-1:0][WIDTH-1:0] bank_rd;

    // Incremented ring indices
    logic [2:0] wr_row_inc;
    logic [2:0] rows_done_inc;

    // Write target: sof restarts the frame at bank 0, x 0 regardless of the
    // current position, so the pixel arriving with sof lands there.
    always_comb begin
        wr_fire     = clken & wr_en;
        wr_bank     = sof ? 3'd0 : wr_row_reg;
        wr_addr     = sof ? '0 : wr_x_reg;
        // End-of-row compare is done against the live img_width, so a new
        // width takes effect at the next compare.
        row_end     = ({{(IW-AWIDTH){1'b0}}, wr_x_reg} == (img_width - 11'd1));
        // A pixel written together with sof sits at x=0; it only closes the
        // row in the degenerate one-pixel-wide case.
        sof_row_end = (img_width == 11'd1);
    end

    // Ring and saturating counter increments
    always_comb begin
        wr_row_inc    = (wr_row_reg == LAST_BANK) ? 3'd0 : (wr_row_reg + 3'd1);
        rows_done_inc = (rows_done_reg == FULL_ROWS) ? FULL_ROWS : (rows_done_reg + 3'd1);
    end

    // Next-state logic for the write position, row ring and status flags
    always_comb begin
        wr_x_next      = wr_x_reg;
        wr_row_next    = wr_row_reg;
        rows_done_next = rows_done_reg;
        row_done_next  = 1'b0;

        if (sof) begin
            // New frame: forget all completed rows. A pixel presented
            // with sof is the first pixel of the new frame.
            wr_x_next      = '0;
            wr_row_next    = 3'd0;
            rows_done_next = 3'd0;
            if (wr_en) begin
                if (sof_row_end) begin
                    wr_row_next    = 3'd1;
                    rows_done_next = 3'd1;
                    row_done_next  = 1'b1;
                end else begin
                    wr_x_next = {{(AWIDTH-1){1'b0}}, 1'b1};
                end
            end
        end else if (wr_en) begin
            if (row_end) begin
                wr_x_next      = '0;
                wr_row_next    = wr_row_inc;
                rows_done_next = rows_done_inc;
                row_done_next  = 1'b1;
            end else begin
                wr_x_next = wr_x_reg + 1'b1;
            end
        end

        // col_ready follows the row count on the same edge it changes
        col_ready_next = (rows_done_next == FULL_ROWS);
    end

    // Control registers; everything holds while clken is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_x_reg      <= '0;
            wr_row_reg    <= 3'd0;
            rows_done_reg <= 3'd0;
            col_ready_reg <= 1'b0;
            row_done_reg  <= 1'b0;
        end else if (clken) begin
            wr_x_reg      <= wr_x_next;
            wr_row_reg    <= wr_row_next;
            rows_done_reg <= rows_done_next;
            col_ready_reg <= col_ready_next;
            row_done_reg  <= row_done_next;
        end
    end

    // Read pipeline bookkeeping: latch the pre-edge wr_row so the lane
    // rotation matches the bank contents captured on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel_reg   <= 3'd0;
            rd_valid_reg <= 1'b0;
        end else if (clken) begin
            rd_sel_reg   <= wr_row_reg;
            rd_valid_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Six row banks, each one write port and one registered read port.
    // Read data registers carry no reset so the banks map onto block RAM;
    // the output is masked to zero until the first enabled read instead.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
            localparam logic [2:0] BANK_ID = 3'(gi);

            logic [WIDTH-1:0] mem [DEPTH];
            logic [WIDTH-1:0] rd_q;

            // Write port: only the bank currently being filled is written
            always_ff @(posedge clk) begin
                if (wr_fire && (wr_bank == BANK_ID)) begin
                    mem[wr_addr] <= wr_data;
                end
            end

            // Read port: every bank is read at rd_addr on each enabled edge
            always_ff @(posedge clk) begin
                if (clken) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign bank_rd[gi] = rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lane rotation: lane i comes from bank (rd_sel + 1 + i) mod 6, giving
    // oldest completed row in lane 0 and newest in lane 4.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
            localparam logic [3:0] OFFSET = 4'(gi + 1);

            logic [3:0]       sum;
            logic [2:0]       bank_idx;
            logic [WIDTH-1:0] lane_data;

            // Select the bank feeding this lane and blank it before the
            // first read after reset
            always_comb begin
                sum       = {1'b0, rd_sel_reg} + OFFSET;
                bank_idx  = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
                lane_data = rd_valid_reg ? bank_rd[bank_idx] : '0;
            end

            assign data_out_col[WIDTH*gi +: WIDTH] = lane_data;
        end
    endgenerate

    assign col_ready = col_ready_reg;
    assign row_done  = row_done_reg;
    assign wr_x      = wr_x_reg;

endmodule

// File: tb/tb_lr_column_buffer.sv
// tb_lr_column_buffer
// Directed scoreboard bench for lr_column_buffer. Each stimulus cycle pushes
// its expected outputs into sb_q; a monitor on the falling edge pops one
// entry for every cycle the stimulus flagged and compares column data and
// status outputs.
module tb_lr_column_buffer;

    localparam int WIDTH  = 16;
    localparam int CWIDTH = 80;
    localparam int AWIDTH = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clken = 1'b0;
    logic [10:0]       img_width = 11'd8;
    logic              sof = 1'b0;
    logic              wr_en = 1'b0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic [AWIDTH-1:0] rd_addr = '0;
    logic [CWIDTH-1:0] data_out_col;
    logic              col_ready;
    logic              row_done;
    logic [AWIDTH-1:0] wr_x;

    typedef struct {
        string             name;
        logic [CWIDTH-1:0] col;
        bit                chk_col;
        bit                cr;
        bit                rdn;
        logic [AWIDTH-1:0] wx;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_req = 1'b0;
    bit   mon_pend = 1'b0;

    // Reference write position / completed-row count for status expectations
    int m_x = 0;
    int m_done = 0;

    localparam logic [CWIDTH-1:0] COL_FILL  = 80'h0043_0033_0023_0013_0003;
    localparam logic [CWIDTH-1:0] COL_ROW5  = 80'h0053_0043_0033_0023_0013;
    localparam logic [CWIDTH-1:0] COL_WRAP  = 80'h00B7_00A7_0097_0087_0077;
    localparam logic [CWIDTH-1:0] COL_GATE  = 80'h00C3_00B3_00A3_0093_0083;
    localparam logic [CWIDTH-1:0] COL_SOF   = 80'h00E1_00D1_00C1_00B1_00A1;
    localparam logic [CWIDTH-1:0] COL_FRM2  = 80'h1040_1030_1020_1010_1000;

    lr_column_buffer #(
        .WIDTH (WIDTH),
        .CWIDTH(CWIDTH),
        .AWIDTH(AWIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clken       (clken),
        .img_width   (img_width),
        .sof         (sof),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .data_out_col(data_out_col),
        .col_ready   (col_ready),
        .row_done    (row_done),
        .wr_x        (wr_x)
    );

    always #5 clk = ~clk;

    // Marks that the edge just taken has an expectation waiting
    always @(posedge clk) mon_pend <= chk_req;

    // Monitor: pop and compare one expectation per flagged edge
    always @(negedge clk) begin
        if (mon_pend) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: output present, got no expected entry (required one)");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn %s: col=%h col_ready=%b row_done=%b wr_x=%0d",
                         e.name, data_out_col, col_ready, row_done, wr_x);
                if (e.chk_col) begin
                    checks++;
                    if (data_out_col !== e.col) begin
                        errors++;
                        $display("FAIL %s data_out_col: got %h required %h", e.name, data_out_col, e.col);
                    end
                end
                checks++;
                if (col_ready !== e.cr) begin
                    errors++;
                    $display("FAIL %s col_ready: got %b required %b", e.name, col_ready, e.cr);
                end
                checks++;
                if (row_done !== e.rdn) begin
                    errors++;
                    $display("FAIL %s row_done: got %b required %b", e.name, row_done, e.rdn);
                end
                checks++;
                if (wr_x !== e.wx) begin
                    errors++;
                    $display("FAIL %s wr_x: got %0d required %0d", e.name, wr_x, e.wx);
                end
            end
        end
    end

    // One clock of stimulus with its expected result queued
    task automatic cyc(input string nm, input logic en, input logic we, input logic s,
                       input logic [WIDTH-1:0] d, input logic [AWIDTH-1:0] a,
                       input bit cc, input logic [CWIDTH-1:0] col,
                       input bit cr, input bit rdn, input logic [AWIDTH-1:0] wx);
        exp_t e;
        e.name = nm; e.col = col; e.chk_col = cc; e.cr = cr; e.rdn = rdn; e.wx = wx;
        sb_q.push_back(e);
        clken = en; wr_en = we; sof = s; wr_data = d; rd_addr = a;
        chk_req = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Write one pixel at img_width=8; status expectation from the row model
    task automatic pix(input string nm, input logic [WIDTH-1:0] d, input logic [AWIDTH-1:0] a,
                       input bit cc, input logic [CWIDTH-1:0] col);
        bit last;
        last = (m_x == 7);
        if (last) begin
            m_x = 0;
            if (m_done < 5) m_done++;
        end else begin
            m_x++;
        end
        cyc(nm, 1'b1, 1'b1, 1'b0, d, a, cc, col, (m_done == 5), last, 9'(m_x));
    endtask

    // Enabled cycle with no write, checking the column returned for a
    task automatic idle_rd(input string nm, input logic [AWIDTH-1:0] a, input logic [CWIDTH-1:0] col);
        cyc(nm, 1'b1, 1'b0, 1'b0, '0, a, 1'b1, col, (m_done == 5), 1'b0, 9'(m_x));
    endtask

    // Full row of 8 pixels with value base + x
    task automatic write_row(input int r, input logic [WIDTH-1:0] base, input logic [AWIDTH-1:0] a,
                             input bit cc, input logic [CWIDTH-1:0] col);
        for (int x = 0; x < 8; x++) begin
            pix($sformatf("row%0d_x%0d", r, x), base + 16'(x), a, cc, col);
        end
    endtask

    initial begin
        // Reset held with random inputs: all outputs zero
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("reset_%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 16'($urandom), 9'($urandom), 1'b1, '0, 1'b0, 1'b0, '0);
        end
        // Reset released with clken low: outputs hold at their reset values
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("hold_%0d", i), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 9'($urandom), 1'b1, '0, 1'b0, 1'b0, '0);
        end

        // Fill rows 0..4, pixel = row*16 + x
        for (int r = 0; r < 5; r++) write_row(r, 16'(r * 16), 9'd0, 1'b0, '0);
        idle_rd("fill_rd3", 9'd3, COL_FILL);

        // Row 5 streams while rows 0..4 are read at x=3
        write_row(5, 16'h0050, 9'd3, 1'b1, COL_FILL);
        idle_rd("row5_rd3", 9'd3, COL_ROW5);

        // Bank wrap: continue up to 12 rows in total
        for (int r = 6; r < 12; r++) write_row(r, 16'(r * 16), 9'd0, 1'b0, '0);
        idle_rd("wrap_rd7", 9'd7, COL_WRAP);

        // clken gating mid-row 12
        for (int x = 0; x < 3; x++) pix($sformatf("row12_x%0d", x), 16'h00C0 + 16'(x), 9'd7, 1'b1, COL_WRAP);
        for (int g = 0; g < 3; g++) begin
            cyc($sformatf("gated_%0d", g), 1'b0, 1'b1, 1'b0, 16'hEEEE, 9'(g), 1'b1, COL_WRAP, 1'b1, 1'b0, 9'd3);
        end
        for (int x = 3; x < 8; x++) pix($sformatf("row12_x%0d", x), 16'h00C0 + 16'(x), 9'd7, 1'b1, COL_WRAP);
        idle_rd("gate_rd3", 9'd3, COL_GATE);

        // sof mid-frame after 2 rows + 3 pixels
        write_row(13, 16'h00D0, 9'd0, 1'b0, '0);
        write_row(14, 16'h00E0, 9'd0, 1'b0, '0);
        for (int x = 0; x < 3; x++) pix($sformatf("row15_x%0d", x), 16'h00F0 + 16'(x), 9'd0, 1'b0, '0);
        m_x = 1;
        m_done = 0;
        cyc("sof", 1'b1, 1'b1, 1'b1, 16'h1000, 9'd1, 1'b1, COL_SOF, 1'b0, 1'b0, 9'd1);
        for (int r = 0; r < 5; r++) begin
            for (int x = (r == 0) ? 1 : 0; x < 8; x++) begin
                pix($sformatf("f2row%0d_x%0d", r, x), 16'h1000 + 16'(r * 16 + x), 9'd0, 1'b0, '0);
            end
        end
        idle_rd("frame2_rd0", 9'd0, COL_FRM2);

        // Drain
        chk_req = 1'b0;
        clken = 1'b0;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
